// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bundle for instr_loader.
// master = stream source / observer, slave = the loader itself.
interface instr_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, in_byte, in_valid,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  core_rst, busy, done, error
    );

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        output core_rst, busy, done, error
    );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> instruction memory words,
// holds the core in reset until a full image lands. Optional trailing checksum: LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int ADDR_W = 10
) (
    input logic           clk,
    input logic           rst,
    instr_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    state_t            state_reg;
    logic [31:0]       len_reg;
    logic [1:0]        lane_reg;
    logic [ADDR_W:0]   word_idx_reg;
    logic [23:0]       word_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [31:0]       wr_data_reg;
    logic              core_rst_reg;
    logic              done_reg;
    logic              error_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        acc_reg;
    logic [7:0]        chk_sum;
`endif

    logic              in_session;
    logic              xfer;
    logic              start_ok;
    logic [31:0]       len_next;
    logic [ADDR_W:0]   word_idx_next;
    logic [31:0]       words_done;

`ifdef LOADER_CHECKSUM_EN
    assign in_session = (state_reg == S_LEN) || (state_reg == S_DATA) || (state_reg == S_CHK);
    assign chk_sum    = acc_reg + bus.in_byte;
`else
    assign in_session = (state_reg == S_LEN) || (state_reg == S_DATA);
`endif

    assign xfer          = bus.in_valid && in_session;
    assign start_ok      = bus.start && !in_session;
    assign len_next      = {bus.in_byte, len_reg[31:8]};
    assign word_idx_next = word_idx_reg + 1'b1;
    assign words_done    = {{(31 - ADDR_W){1'b0}}, word_idx_next};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            len_reg      <= '0;
            lane_reg     <= '0;
            word_idx_reg <= '0;
            word_reg     <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            core_rst_reg <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            acc_reg      <= '0;
`endif
        end else begin
            wr_en_reg <= 1'b0;
            if (start_ok) begin
                // New session: core goes back into reset while the image is replaced
                state_reg    <= S_LEN;
                len_reg      <= '0;
                lane_reg     <= '0;
                word_idx_reg <= '0;
                core_rst_reg <= 1'b0;
                done_reg     <= 1'b0;
                error_reg    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                acc_reg      <= '0;
`endif
            end else begin
                case (state_reg)
                    S_LEN: if (xfer) begin
                        len_reg  <= len_next;
                        lane_reg <= lane_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        acc_reg  <= acc_reg + bus.in_byte;
`endif
                        if (lane_reg == 2'd3) begin
                            if ({1'b0, len_next} > CAPACITY) begin
                                state_reg <= S_ERR;
                                error_reg <= 1'b1;
                            end else if (len_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_reg <= S_CHK;
`else
                                state_reg <= S_DONE;
                                done_reg  <= 1'b1;
`endif
                            end else begin
                                state_reg <= S_DATA;
                            end
                        end
                    end
                    S_DATA: if (xfer) begin
                        lane_reg <= lane_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        acc_reg  <= acc_reg + bus.in_byte;
`endif
                        case (lane_reg)
                            2'd0:    word_reg[7:0]   <= bus.in_byte;
                            2'd1:    word_reg[15:8]  <= bus.in_byte;
                            2'd2:    word_reg[23:16] <= bus.in_byte;
                            default: begin
                                wr_en_reg    <= 1'b1;
                                wr_addr_reg  <= word_idx_reg[ADDR_W-1:0];
                                wr_data_reg  <= {bus.in_byte, word_reg};
                                word_idx_reg <= word_idx_next;
                                if (words_done == len_reg) begin
`ifdef LOADER_CHECKSUM_EN
                                    state_reg <= S_CHK;
`else
                                    state_reg <= S_DONE;
                                    done_reg  <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: if (xfer) begin
                        if (chk_sum == 8'd0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_ERR;
                            error_reg <= 1'b1;
                        end
                    end
`endif
                    // Release trails Done by a cycle so the final write lands first
                    S_DONE:  core_rst_reg <= 1'b1;
                    S_ERR:   core_rst_reg <= 1'b0;
                    S_IDLE:  core_rst_reg <= 1'b0;
                    default: state_reg    <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready    = in_session;
    assign bus.busy        = in_session;
    assign bus.mem_wr_en   = wr_en_reg;
    assign bus.mem_wr_addr = wr_addr_reg;
    assign bus.mem_wr_data = wr_data_reg;
    assign bus.core_rst    = core_rst_reg;
    assign bus.done        = done_reg;
    assign bus.error       = error_reg;
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed vector table, mid-session reset, and random
// sessions checked against a stream-level reference model.
`timescale 1ns/1ps
module tb_instr_loader;
    localparam int ADDR_W = 4;
    localparam int CAP    = 1 << ADDR_W;

    typedef struct packed {
        logic [127:0] s;
        logic [7:0]   nb;
        logic         use_ck;
        logic [7:0]   ck;
        logic         rv;
        logic         exp_done;
        logic [7:0]   exp_nw;
        logic [31:0]  w0;
        logic [31:0]  w1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0]        stream_q[$];
    int                acc_cyc_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                wr_cyc_q[$];
    logic [31:0]       exp_data_q[$];
    vec_t              vecs[8];
    int                nvec;

    instr_loader_if #(.ADDR_W(ADDR_W)) bus();
    instr_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            wr_addr_q.push_back(bus.mem_wr_addr);
            wr_data_q.push_back(bus.mem_wr_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic [127:0] s, input int nb, input bit use_ck,
                                   input logic [7:0] ck, input bit rv, input bit d,
                                   input int nw, input logic [31:0] w0, input logic [31:0] w1);
        vec_t v;
        v.s = s; v.nb = 8'(nb); v.use_ck = use_ck; v.ck = ck; v.rv = rv;
        v.exp_done = d; v.exp_nw = 8'(nw); v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    task automatic clear_queues();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", bus.busy, 1);
        chk("ready_after_start", bus.in_ready, 1);
        chk("done_cleared", bus.done, 0);
        chk("error_cleared", bus.error, 0);
        chk("corerst_held", bus.core_rst, 0);
        @(posedge clk); #1;
    endtask

    task automatic drive_stream(input bit rv, input bit poke_start);
        int idx = 0;
        int budget = 0;
        acc_cyc_q.delete();
        while (idx < stream_q.size() && budget < 400) begin
            logic v;
            logic rdy;
            v = rv ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = v;
            bus.in_byte  = v ? stream_q[idx] : 8'($urandom);
            bus.start    = poke_start && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (v && rdy) begin
                acc_cyc_q.push_back(cyc);
                idx++;
            end
            budget++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk("stream_consumed", idx, stream_q.size());
    endtask

    task automatic check_session(input bit exp_done);
        int nw;
        @(negedge clk);
        chk("done_flag", bus.done, exp_done);
        chk("error_flag", bus.error, !exp_done);
        chk("corerst_with_done", bus.core_rst, 0);
        chk("busy_end", bus.busy, 0);
        chk("ready_end", bus.in_ready, 0);
        @(negedge clk);
        chk("corerst_release", bus.core_rst, exp_done);
        chk("write_count", wr_data_q.size(), exp_data_q.size());
        nw = (wr_data_q.size() < exp_data_q.size()) ? wr_data_q.size() : exp_data_q.size();
        for (int i = 0; i < nw; i++) begin
            chk("wr_addr", wr_addr_q[i], i);
            chk("wr_data", wr_data_q[i], exp_data_q[i]);
            if (7 + 4 * i < acc_cyc_q.size())
                chk("wr_timing", wr_cyc_q[i], acc_cyc_q[7 + 4 * i]);
        end
        if (exp_data_q.size() > 0) begin
            chk("addr_hold", bus.mem_wr_addr, exp_data_q.size() - 1);
            chk("data_hold", bus.mem_wr_data, exp_data_q[exp_data_q.size() - 1]);
        end
        // bytes offered outside a session must be ignored
        nw = wr_data_q.size();
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h5a;
        repeat (3) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        chk("idle_no_write", wr_data_q.size(), nw);
        chk("state_held", bus.done, exp_done);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int nb;
        v  = vecs[k];
        nb = int'(v.nb);
        stream_q.delete();
        for (int j = 0; j < nb; j++) stream_q.push_back(v.s[(nb - 1 - j) * 8 +: 8]);
`ifdef LOADER_CHECKSUM_EN
        if (v.use_ck) stream_q.push_back(v.ck);
`endif
        exp_data_q.delete();
        if (v.exp_nw >= 1) exp_data_q.push_back(v.w0);
        if (v.exp_nw >= 2) exp_data_q.push_back(v.w1);
        clear_queues();
        do_start();
        drive_stream(v.rv, 1'b0);
        check_session(v.exp_done);
    endtask

    // Reference: interpret the stream by its format, independent of loader internals
    task automatic model_expect(output bit exp_done);
        int unsigned n;
        exp_data_q.delete();
        n = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
        exp_done = 1'b0;
        if (n > CAP) return;
        for (int unsigned i = 0; i < n; i++)
            exp_data_q.push_back({stream_q[4*i+7], stream_q[4*i+6], stream_q[4*i+5], stream_q[4*i+4]});
        exp_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        begin
            int sum = 0;
            foreach (stream_q[j]) sum += int'(stream_q[j]);
            exp_done = ((sum % 256) == 0);
        end
`endif
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        nvec = 0;
        vecs[nvec++] = mkvec(128'h02000000_13000000_93001000, 12, 1, 8'h48, 0, 1, 2, 32'h00000013, 32'h00100093);
        vecs[nvec++] = mkvec(128'h02000000_13000000_93001000, 12, 1, 8'h48, 1, 1, 2, 32'h00000013, 32'h00100093);
        vecs[nvec++] = mkvec(128'h00000000, 4, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0);
        vecs[nvec++] = mkvec(128'h11000000, 4, 0, 8'h00, 0, 0, 0, 32'h0, 32'h0);
        vecs[nvec++] = mkvec(128'h00010000, 4, 0, 8'h00, 1, 0, 0, 32'h0, 32'h0);
        vecs[nvec++] = mkvec(128'h00000001, 4, 0, 8'h00, 1, 0, 0, 32'h0, 32'h0);
        vecs[nvec++] = mkvec(128'h01000000_efbeadde, 8, 1, 8'hc7, 1, 1, 1, 32'hdeadbeef, 32'h0);
`ifdef LOADER_CHECKSUM_EN
        vecs[nvec++] = mkvec(128'h02000000_13000000_93001000, 12, 1, 8'h49, 0, 0, 2, 32'h00000013, 32'h00100093);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mem_wr_en", bus.mem_wr_en, 0);
        chk("rst_mem_wr_addr", bus.mem_wr_addr, 0);
        chk("rst_mem_wr_data", bus.mem_wr_data, 0);
        chk("rst_core_rst", bus.core_rst, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < nvec; k++) run_vec(k);

        // Reset lands on the edge that would complete word 0: strobe must be cancelled
        stream_q.delete();
        stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00};
        clear_queues();
        do_start();
        drive_stream(1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h00;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_mem_wr_en", bus.mem_wr_en, 0);
        chk("midrst_mem_wr_addr", bus.mem_wr_addr, 0);
        chk("midrst_mem_wr_data", bus.mem_wr_data, 0);
        chk("midrst_core_rst", bus.core_rst, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_error", bus.error, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_write", wr_data_q.size(), 0);
        run_vec(0);

        for (int it = 0; it < 40; it++) begin
            int unsigned n;
            bit ed;
            case (it)
                0:       n = CAP;
                1:       n = CAP + 1;
                2:       n = 32'h0000_0100;
                default: n = $urandom_range(0, CAP + 1);
            endcase
            stream_q.delete();
            stream_q.push_back(n[7:0]);
            stream_q.push_back(n[15:8]);
            stream_q.push_back(n[23:16]);
            stream_q.push_back(n[31:24]);
            if (n <= CAP) begin
                for (int unsigned i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
                begin
                    int sum = 0;
                    logic [7:0] ck;
                    foreach (stream_q[j]) sum += int'(stream_q[j]);
                    ck = 8'((256 - (sum % 256)) % 256);
                    if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
                    stream_q.push_back(ck);
                end
`endif
            end
            model_expect(ed);
            clear_queues();
            do_start();
            drive_stream(1'b1, 1'b1);
            check_session(ed);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
